// File: rtl/mest_pro_seq_ctrlr.sv
// Program sequencer: fetch/decode/execute loop with single-step hold,
// abort, and a saturating retired-instruction counter.
//
// state   | meaning
// IDLE    | waiting for i_start
// FETCH   | waiting for i_mem_ready
// DECODE  | one cycle, loads execute length
// EXECUTE | runs the loaded number of cycles
// HOLD    | single-step pause, waiting for i_step
module mest_pro_seq_ctrlr #(
  parameter int EXEC_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_end_of_code,
  input  logic              i_mem_ready,
  input  logic [EXEC_W-1:0] i_exec_cycles,
  input  logic              i_step_mode,
  input  logic              i_step,
  input  logic              i_abort,
  output logic              o_idle,
  output logic              o_fetch,
  output logic              o_decode,
  output logic              o_execute,
  output logic              o_hold,
  output logic              o_exec_last,
  output logic              o_all_done,
  output logic [CNT_W-1:0]  o_instr_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [EXEC_W-1:0] exec_cnt;
  logic              abort_act;

  assign abort_act = i_abort & (state != IDLE);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = i_start ? FETCH : IDLE;
      FETCH:   state_nxt = i_mem_ready ? DECODE : FETCH;
      DECODE:  state_nxt = EXECUTE;
      EXECUTE: begin
        if (!o_exec_last)       state_nxt = EXECUTE;
        else if (i_end_of_code) state_nxt = IDLE;
        else if (i_step_mode)   state_nxt = HOLD;
        else                    state_nxt = FETCH;
      end
      HOLD:    state_nxt = i_step ? FETCH : HOLD;
      default: state_nxt = IDLE;
    endcase
    if (abort_act) state_nxt = IDLE;
  end

  // Down-counter; terminal count of 1 marks the final execute cycle.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      exec_cnt <= '0;
    end else if (abort_act) begin
      exec_cnt <= '0;
    end else if (state == DECODE) begin
      exec_cnt <= (i_exec_cycles == '0) ? EXEC_W'(1) : i_exec_cycles;
    end else if (state == EXECUTE) begin
      exec_cnt <= exec_cnt - EXEC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_instr_count <= '0;
    end else if (state == IDLE && i_start) begin
      o_instr_count <= '0;
    end else if (o_exec_last && !i_abort && o_instr_count != '1) begin
      o_instr_count <= o_instr_count + CNT_W'(1);
    end
  end

  // Illegal encodings read as idle so the indicators stay one-hot.
  assign o_fetch     = (state == FETCH);
  assign o_decode    = (state == DECODE);
  assign o_execute   = (state == EXECUTE);
  assign o_hold      = (state == HOLD);
  assign o_idle      = ~(o_fetch | o_decode | o_execute | o_hold);
  assign o_exec_last = o_execute & (exec_cnt == EXEC_W'(1));
  assign o_all_done  = o_exec_last & i_end_of_code & ~i_abort;

endmodule

// File: tb/tb_mest_pro_seq_ctrlr.sv
// Directed bench for mest_pro_seq_ctrlr; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_mest_pro_seq_ctrlr;

  logic       clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_start = 1'b0, i_end_of_code = 1'b0, i_mem_ready = 1'b0;
  logic [3:0] i_exec_cycles = 4'd0;
  logic       i_step_mode = 1'b0, i_step = 1'b0, i_abort = 1'b0;

  logic        o_idle, o_fetch, o_decode, o_execute, o_hold, o_exec_last, o_all_done;
  logic [15:0] o_instr_count;
  logic        idle2, fetch2, decode2, execute2, hold2, exec_last2, all_done2;
  logic [1:0]  count2;

  logic [4:0] st;
  assign st = {o_idle, o_fetch, o_decode, o_execute, o_hold};

  localparam logic [4:0] ST_I = 5'b10000, ST_F = 5'b01000, ST_D = 5'b00100,
                         ST_E = 5'b00010, ST_H = 5'b00001;

  int n_chk = 0, n_fail = 0, pulses = 0;

  mest_pro_seq_ctrlr #(.EXEC_W(4), .CNT_W(16)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_end_of_code(i_end_of_code),
    .i_mem_ready(i_mem_ready), .i_exec_cycles(i_exec_cycles), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_abort(i_abort), .o_idle(o_idle), .o_fetch(o_fetch),
    .o_decode(o_decode), .o_execute(o_execute), .o_hold(o_hold), .o_exec_last(o_exec_last),
    .o_all_done(o_all_done), .o_instr_count(o_instr_count)
  );

  mest_pro_seq_ctrlr #(.EXEC_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_end_of_code(i_end_of_code),
    .i_mem_ready(i_mem_ready), .i_exec_cycles(i_exec_cycles), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_abort(i_abort), .o_idle(idle2), .o_fetch(fetch2),
    .o_decode(decode2), .o_execute(execute2), .o_hold(hold2), .o_exec_last(exec_last2),
    .o_all_done(all_done2), .o_instr_count(count2)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts in FETCH with i_mem_ready=1; runs one instruction of n cycles.
  task automatic instr(input int n, input logic eoc);
    chk("fetch", 32'(st), 32'(ST_F));
    i_exec_cycles = 4'(n);
    cyc();
    chk("decode", 32'(st), 32'(ST_D));
    cyc();
    for (int i = 1; i <= n; i++) begin
      chk("exec", 32'(st), 32'(ST_E));
      if (i == n) i_end_of_code = eoc;
      #1;
      chk("exec_last", 32'(o_exec_last), 32'(i == n));
      if (o_all_done) pulses++;
      cyc();
    end
    i_end_of_code = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_state", 32'(st), 32'(ST_I));
    chk("rst_last", 32'(o_exec_last), 0);
    chk("rst_done", 32'(o_all_done), 0);
    chk("rst_count", 32'(o_instr_count), 0);
    cyc(); cyc();
    i_reset_n = 1'b1;

    // Single instruction, exec length 0 treated as 1
    i_start = 1'b1; i_mem_ready = 1'b1; i_exec_cycles = 4'd0; i_end_of_code = 1'b1;
    cyc();
    i_start = 1'b0;
    chk("t1_fetch", 32'(st), 32'(ST_F));
    cyc();
    chk("t1_decode", 32'(st), 32'(ST_D));
    cyc();
    chk("t1_exec", 32'(st), 32'(ST_E));
    chk("t1_last", 32'(o_exec_last), 1);
    chk("t1_done", 32'(o_all_done), 1);
    cyc();
    chk("t1_idle", 32'(st), 32'(ST_I));
    chk("t1_done_off", 32'(o_all_done), 0);
    chk("t1_count", 32'(o_instr_count), 1);

    // Fetch stall and 5-cycle execute; length change during execute ignored
    i_start = 1'b1; i_mem_ready = 1'b0; i_exec_cycles = 4'd5;
    cyc();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_fetch", 32'(st), 32'(ST_F));
      if (i == 3) i_mem_ready = 1'b1;
      cyc();
    end
    chk("t2_decode", 32'(st), 32'(ST_D));
    cyc();
    i_exec_cycles = 4'd1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk("t2_exec", 32'(st), 32'(ST_E));
      chk("t2_last", 32'(o_exec_last), 32'(i == 5));
      chk("t2_done", 32'(o_all_done), 32'(i == 5));
      @(posedge clk); #1;
    end
    chk("t2_idle", 32'(st), 32'(ST_I));
    chk("t2_count", 32'(o_instr_count), 1);
    i_end_of_code = 1'b0;

    // Single-step over three instructions
    i_step_mode = 1'b1; pulses = 0;
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      instr(2, k == 3);
      if (k < 3) begin
        for (int h = 0; h < 3; h++) begin
          chk("t3_hold", 32'(st), 32'(ST_H));
          i_start = 1'b1;
          cyc();
        end
        i_start = 1'b0; i_step = 1'b1;
        chk("t3_hold_rel", 32'(st), 32'(ST_H));
        cyc();
        i_step = 1'b0;
      end
    end
    chk("t3_idle", 32'(st), 32'(ST_I));
    chk("t3_count", 32'(o_instr_count), 3);
    chk("t3_pulses", 32'(pulses), 1);
    i_step_mode = 1'b0;

    // Abort on final execute cycle, then abort+start in IDLE
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    instr(1, 1'b0);
    chk("t4_count1", 32'(o_instr_count), 1);
    chk("t4_fetch", 32'(st), 32'(ST_F));
    i_exec_cycles = 4'd1;
    cyc();
    cyc();
    chk("t4_exec", 32'(st), 32'(ST_E));
    i_end_of_code = 1'b1; i_abort = 1'b1;
    #1;
    chk("t4_last", 32'(o_exec_last), 1);
    chk("t4_no_done", 32'(o_all_done), 0);
    cyc();
    i_abort = 1'b0; i_end_of_code = 1'b0;
    chk("t4_idle", 32'(st), 32'(ST_I));
    chk("t4_count_held", 32'(o_instr_count), 1);
    i_abort = 1'b1; i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    chk("t4_abort_start", 32'(st), 32'(ST_F));
    cyc();
    chk("t4_abort_fetch", 32'(st), 32'(ST_I));
    i_abort = 1'b0;

    // Saturation on the 2-bit instance, then async reset mid-execute
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      instr(1, 1'b0);
      chk("t5_count", 32'(o_instr_count), 32'(k));
      chk("t5_count_sat", 32'(count2), 32'((k < 3) ? k : 3));
    end
    i_exec_cycles = 4'd3;
    cyc();
    cyc();
    cyc();
    chk("t5_exec", 32'(st), 32'(ST_E));
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("t5_rst_state", 32'(st), 32'(ST_I));
    chk("t5_rst_last", 32'(o_exec_last), 0);
    chk("t5_rst_count", 32'(o_instr_count), 0);
    chk("t5_rst_count2", 32'(count2), 0);
    cyc();
    i_reset_n = 1'b1; i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    chk("t5_post_rst", 32'(st), 32'(ST_F));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
